// File: rtl/cmd_bus_pkg.sv
// rtl/cmd_bus_pkg.sv - shared command bus widths, reset value and assembler state encoding
package cmd_bus_pkg;
    localparam int CMD_W  = 16;
    localparam int BYTE_W = 8;

    localparam logic [CMD_W-1:0] CMD_RESET_VALUE = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HIGH  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_GAP   = 2'd3
    } cmd_state_e;
endpackage

// File: rtl/cmd_timeout_timer.sv
// rtl/cmd_timeout_timer.sv - loadable up-counter with clear, enable and terminal-count compare
module cmd_timeout_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic [WIDTH-1:0] tc_val_i,
    output logic             tc_o
);
    logic [WIDTH-1:0] count_q, count_d;

    // Clear has priority so a restart never sees a stale load or increment.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (en_i) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == tc_val_i);
endmodule

// File: rtl/cmd_word_assembler.sv
// rtl/cmd_word_assembler.sv - pairs host bytes into Cmd words with Cmd_En strobe; timeout under CMD_TIMEOUT_EN
module cmd_word_assembler
    import cmd_bus_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000,
    parameter logic [3:0]  CMD_GAP        = 4'd2
) (
    input  logic              Clk_In,
    input  logic              Rst_N,
    input  logic [BYTE_W:1]   Byte_In,
    input  logic              Byte_Valid,
    output logic              Byte_Ready,
    output logic [CMD_W:1]    Cmd,
    output logic              Cmd_En,
    output logic [CMD_W:1]    Cmd_Count,
    output logic              Timeout_Pulse
);
    cmd_state_e        state_q, state_d;
    logic              byte_ready_q, byte_ready_d;
    logic [BYTE_W-1:0] high_q, high_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic [CMD_W-1:0]  cmd_count_q, cmd_count_d;
    logic              xfer;
    logic              gap_done;
    logic              timeout_hit;

    assign xfer = Byte_Valid && byte_ready_q;

    cmd_timeout_timer #(
        .WIDTH(4)
    ) u_gap_timer (
        .clk_i      (Clk_In),
        .resetn_i   (Rst_N),
        .clr_i      (state_q == ST_ISSUE),
        .en_i       (state_q == ST_GAP),
        .load_i     (1'b0),
        .load_val_i (4'd0),
        .tc_val_i   (CMD_GAP - 4'd1),
        .tc_o       (gap_done)
    );

`ifdef CMD_TIMEOUT_EN
    logic timeout_tc;

    // Every transfer restarts the wait, which also covers entry into HIGH.
    cmd_timeout_timer #(
        .WIDTH(16)
    ) u_timeout_timer (
        .clk_i      (Clk_In),
        .resetn_i   (Rst_N),
        .clr_i      (xfer),
        .en_i       (state_q == ST_HIGH),
        .load_i     (1'b0),
        .load_val_i (16'd0),
        .tc_val_i   (TIMEOUT_CYCLES),
        .tc_o       (timeout_tc)
    );

    assign timeout_hit = (state_q == ST_HIGH) && timeout_tc && !xfer;
`else
    logic timeout_cfg_unused;

    assign timeout_cfg_unused = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge Clk_In) begin
        if (!Rst_N) begin
            state_q      <= ST_IDLE;
            byte_ready_q <= 1'b0;
            high_q       <= '0;
            cmd_q        <= CMD_RESET_VALUE;
            cmd_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            byte_ready_q <= byte_ready_d;
            high_q       <= high_d;
            cmd_q        <= cmd_d;
            cmd_count_q  <= cmd_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (xfer) begin
                    state_d = ST_ISSUE;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = (CMD_GAP != 4'd0) ? ST_GAP : ST_IDLE;
            end
            ST_GAP: begin
                if (gap_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Ready is registered from the next state so it never follows Byte_Valid.
    always_comb begin
        byte_ready_d = (state_d == ST_IDLE) || (state_d == ST_HIGH);
        high_d       = high_q;
        cmd_d        = cmd_q;
        cmd_count_d  = cmd_count_q;
        if ((state_q == ST_IDLE) && xfer) begin
            high_d = Byte_In;
        end
        if ((state_q == ST_HIGH) && xfer) begin
            cmd_d       = {high_q, Byte_In};
            cmd_count_d = cmd_count_q + 16'd1;
        end
    end

    assign Byte_Ready    = byte_ready_q;
    assign Cmd           = cmd_q;
    assign Cmd_En        = (state_q == ST_ISSUE);
    assign Cmd_Count     = cmd_count_q;
    assign Timeout_Pulse = timeout_hit;
endmodule
